// File: rtl/sample_replay_buffer.sv
// Captures each host sample line while forwarding it to the dot stage, then
// replays the stored sample in order to the update stage once it is complete.
module sample_replay_buffer #(
  parameter int LINE_WIDTH = 512,
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_start,
  input  logic [31:0]           regs0,
  output logic                  op_done,
  output logic                  op_error,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  input  logic [LINE_WIDTH-1:0] in_tdata,
  output logic                  dot_tvalid,
  input  logic                  dot_tready,
  output logic [LINE_WIDTH-1:0] dot_tdata,
  output logic                  upd_tvalid,
  input  logic                  upd_tready,
  output logic [LINE_WIDTH-1:0] upd_tdata
);

  localparam int IDX_W = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_REPLAY, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      len_q, len_d;
  logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]      out_cnt_q, out_cnt_d;
  logic [1:0]            skid_cnt_q, skid_cnt_d;
  logic                  rd_vld_p1_q, rd_vld_p1_d;
  logic                  op_done_q, op_done_d;
  logic                  op_error_q, op_error_d;
  logic [LINE_WIDTH-1:0] rd_data_p1_q;
  logic [LINE_WIDTH-1:0] skid0_q, skid0_d;
  logic [LINE_WIDTH-1:0] skid1_q, skid1_d;
  logic [LINE_WIDTH-1:0] mem [DEPTH];

  logic [15:0]           req_len;
  logic                  len_ok;
  logic                  start_ok;
  logic                  start_bad;
  logic                  in_hs;
  logic                  upd_pop;
  logic                  rd_issue;
  logic [2:0]            occ_after;
  logic [1:0]            push_slot;
  logic                  unused_regs0_lo;

  assign unused_regs0_lo = ^regs0[15:0];
  assign req_len   = regs0[31:16];
  assign len_ok    = (req_len != 16'd0) && (req_len <= 16'(DEPTH));
  assign start_ok  = (state_q == S_IDLE) && op_start && len_ok;
  assign start_bad = (state_q == S_IDLE) && op_start && !len_ok;
  assign in_hs     = (state_q == S_CAPTURE) && in_tvalid && dot_tready;
  assign upd_pop   = upd_tvalid && upd_tready;

  // A read lands in the skid one cycle after issue, so only issue when the
  // skid will hold at most one line after this cycle's push and pop.
  assign occ_after = 3'(skid_cnt_q) + 3'(rd_vld_p1_q) - 3'(upd_pop);
  assign rd_issue  = (state_q == S_REPLAY) && (rd_idx_q < len_q) && (occ_after <= 3'd1);
  assign push_slot = skid_cnt_q - {1'b0, upd_pop};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_ok) state_d = S_CAPTURE;
      S_CAPTURE: if (in_hs && (wr_idx_q == len_q - IDX_W'(1))) state_d = S_REPLAY;
      S_REPLAY:  if (upd_pop && (out_cnt_q == len_q - IDX_W'(1))) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs: capture is a pure combinational pass-through gated by state
  always_comb begin
    in_tready  = (state_q == S_CAPTURE) && dot_tready;
    dot_tvalid = (state_q == S_CAPTURE) && in_tvalid;
    dot_tdata  = in_tdata;
    upd_tvalid = (state_q == S_REPLAY) && (skid_cnt_q != 2'd0);
    upd_tdata  = skid0_q;
    op_done    = op_done_q;
    op_error   = op_error_q;
  end

  always_comb begin
    len_d       = len_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    out_cnt_d   = out_cnt_q;
    if ((state_q == S_IDLE) && op_start) begin
      len_d     = req_len[IDX_W-1:0];
      wr_idx_d  = '0;
      rd_idx_d  = '0;
      out_cnt_d = '0;
    end
    if (in_hs)    wr_idx_d  = wr_idx_q + IDX_W'(1);
    if (rd_issue) rd_idx_d  = rd_idx_q + IDX_W'(1);
    if (upd_pop)  out_cnt_d = out_cnt_q + IDX_W'(1);
    rd_vld_p1_d = rd_issue;
    skid_cnt_d  = skid_cnt_q + {1'b0, rd_vld_p1_q} - {1'b0, upd_pop};
    op_done_d   = (state_q == S_DONE) || start_bad;
    op_error_d  = start_bad;
  end

  // Output skid: head is always slot 0; a pop shifts slot 1 forward
  always_comb begin
    skid0_d = skid0_q;
    skid1_d = skid1_q;
    if (upd_pop) skid0_d = skid1_q;
    if (rd_vld_p1_q) begin
      if (push_slot == 2'd0) skid0_d = rd_data_p1_q;
      else                   skid1_d = rd_data_p1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q       <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      out_cnt_q   <= '0;
      skid_cnt_q  <= '0;
      rd_vld_p1_q <= 1'b0;
      op_done_q   <= 1'b0;
      op_error_q  <= 1'b0;
    end else begin
      len_q       <= len_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      out_cnt_q   <= out_cnt_d;
      skid_cnt_q  <= skid_cnt_d;
      rd_vld_p1_q <= rd_vld_p1_d;
      op_done_q   <= op_done_d;
      op_error_q  <= op_error_d;
    end
  end

  // Data path: buffer contents and skid data are never cleared
  always_ff @(posedge clk) begin
    skid0_q <= skid0_d;
    skid1_q <= skid1_d;
    if (in_hs)    mem[wr_idx_q[ADDR_W-1:0]] <= in_tdata;
    if (rd_issue) rd_data_p1_q <= mem[rd_idx_q[ADDR_W-1:0]];
  end

endmodule
